// File: rtl/carry_chain_pkg.sv
// Shared constants for the carry-chain pipeline: slice width and stage count.
package carry_chain_pkg;

  localparam int SLICE_W = 4;

  function automatic int num_stages(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/carry_chain_slice.sv
// One registered 4-bit carry-mux stage: S/DI generation, mux carry chain, enabled register.
module carry_chain_slice
  import carry_chain_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               ci_i,
  output logic [SLICE_W-1:0] o_o,
  output logic               co_o
);

  logic [SLICE_W-1:0] s;
  logic [SLICE_W-1:0] di;
  logic [SLICE_W:0]   c;
  logic [SLICE_W-1:0] o_d;
  logic               co_d;
  logic [SLICE_W-1:0] o_q;
  logic               co_q;

  // b_i arrives already conditionally inverted for subtraction
  always_comb begin
    s    = a_i ^ b_i;
    di   = a_i;
    c    = '0;
    o_d  = '0;
    c[0] = ci_i;
    for (int i = 0; i < SLICE_W; i++) begin
      c[i+1] = s[i] ? c[i] : di[i];
      o_d[i] = s[i] ^ c[i];
    end
    co_d = c[SLICE_W];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      o_q  <= '0;
      co_q <= 1'b0;
    end else if (en_i) begin
      o_q  <= o_d;
      co_q <= co_d;
    end
  end

  assign o_o  = o_q;
  assign co_o = co_q;

endmodule

// File: rtl/carry_chain_pipe.sv
// Pipelined add/sub: one 4-bit carry slice per stage, operands skewed in and results deskewed out.
// Defining CARRY_CHAIN_PIPE_OVF_EN adds the signed-overflow output OVF.
module carry_chain_pipe
  import carry_chain_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = num_stages(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] O,
  output logic             CO
`ifdef CARRY_CHAIN_PIPE_OVF_EN
  ,
  output logic             OVF
`endif
);

  logic                              adv;
  logic [STAGES-1:0]                 valid_q;
  logic [WIDTH-1:0]                  b_eff;
  logic [WIDTH-1:0]                  a_skew_q  [STAGES-1];
  logic [WIDTH-1:0]                  b_skew_q  [STAGES-1];
  logic [WIDTH-SLICE_W-1:0]          res_dsk_q [STAGES-1];
  logic [STAGES-1:0][SLICE_W-1:0]    slice_o;
  logic [STAGES-1:0]                 slice_co;

  assign adv       = !valid_q[STAGES-1] || OUT_READY;
  assign IN_READY  = adv;
  assign OUT_VALID = valid_q[STAGES-1];
  assign b_eff     = SUB ? ~B : B;

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q <= {valid_q[STAGES-2:0], IN_VALID};
    end
  end

  // Skew: each rank drops the nibble its slice just consumed
  always_ff @(posedge CLK) begin
    if (adv) begin
      a_skew_q[0] <= A >> SLICE_W;
      b_skew_q[0] <= b_eff >> SLICE_W;
      for (int k = 1; k < STAGES-1; k++) begin
        a_skew_q[k] <= a_skew_q[k-1] >> SLICE_W;
        b_skew_q[k] <= b_skew_q[k-1] >> SLICE_W;
      end
    end
  end

  // Deskew: finished nibbles shift down as new ones enter at the top
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < STAGES-1; k++) res_dsk_q[k] <= '0;
    end else if (adv) begin
      res_dsk_q[0] <= (WIDTH-SLICE_W)'(slice_o[0]) << (WIDTH - 2*SLICE_W);
      for (int k = 1; k < STAGES-1; k++) begin
        res_dsk_q[k] <= {slice_o[k], res_dsk_q[k-1][WIDTH-SLICE_W-1:SLICE_W]};
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SLICE_W-1:0] a_s;
    logic [SLICE_W-1:0] b_s;
    logic               ci;

    if (k == 0) begin : g_head
      assign a_s = A[SLICE_W-1:0];
      assign b_s = b_eff[SLICE_W-1:0];
      assign ci  = SUB;
    end else begin : g_body
      assign a_s = a_skew_q[k-1][SLICE_W-1:0];
      assign b_s = b_skew_q[k-1][SLICE_W-1:0];
      assign ci  = slice_co[k-1];
    end

    carry_chain_slice u_slice (
      .clk_i (CLK),
      .rst_i (RST),
      .en_i  (adv),
      .a_i   (a_s),
      .b_i   (b_s),
      .ci_i  (ci),
      .o_o   (slice_o[k]),
      .co_o  (slice_co[k])
    );
  end

  assign O  = {slice_o[STAGES-1], res_dsk_q[STAGES-2]};
  assign CO = slice_co[STAGES-1];

`ifdef CARRY_CHAIN_PIPE_OVF_EN
  // Same-sign operands giving an opposite-sign result is equivalent to MSB carry-in XOR carry-out
  logic a_msb_q;
  logic b_msb_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (adv) begin
      a_msb_q <= a_skew_q[STAGES-2][SLICE_W-1];
      b_msb_q <= b_skew_q[STAGES-2][SLICE_W-1];
    end
  end

  assign OVF = (a_msb_q == b_msb_q) && (O[WIDTH-1] != a_msb_q);
`endif

endmodule

// File: tb/tb_carry_chain_pipe.sv
// Scoreboard bench for carry_chain_pipe: directed beats, stall, random back-pressure, mid-stream reset.
module tb_carry_chain_pipe;

  localparam int WIDTH  = 16;
  localparam int STAGES = WIDTH / 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SUB;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] O;
  logic             CO;
`ifdef CARRY_CHAIN_PIPE_OVF_EN
  logic             OVF;
`endif

  typedef struct {
    logic [WIDTH-1:0] o;
    logic             co;
    logic             ovf;
    int unsigned      cyc;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               n_assert = 0;
  int               n_fail   = 0;
  int unsigned      cyc      = 0;
  bit               chk_lat  = 1'b0;
  bit               held     = 1'b0;
  logic [WIDTH-1:0] held_o;
  logic             held_co;
  int               g;

  carry_chain_pipe #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .SUB       (SUB),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .O         (O),
    .CO        (CO)
`ifdef CARRY_CHAIN_PIPE_OVF_EN
    ,
    .OVF       (OVF)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s, input int unsigned c);
    exp_t           r;
    logic [WIDTH:0] sx;
    if (s) begin
      r.o  = a - b;
      r.co = (a >= b);
      sx   = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    end else begin
      {r.co, r.o} = {1'b0, a} + {1'b0, b};
      sx          = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    end
    r.ovf = sx[WIDTH] ^ sx[WIDTH-1];
    r.cyc = c;
    return r;
  endfunction

  // Monitor: handshakes sampled mid-cycle, ahead of the edge that completes them
  always @(negedge CLK) begin
    if (RST) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_hold_valid", OUT_VALID, 1'b1);
        chk("stall_hold_o", O, held_o);
        chk("stall_hold_co", CO, held_co);
      end
      held = 1'b0;
      if (OUT_VALID && OUT_READY) begin
        n_assert++;
        assert ((sb.size() > 0) === 1'b1) else begin
          n_fail++;
          $error("FAIL unexpected_beat: observed O=%h CO=%b, expected no beat", O, CO);
        end
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("result_o", O, mon_e.o);
          chk("result_co", CO, mon_e.co);
`ifdef CARRY_CHAIN_PIPE_OVF_EN
          chk("result_ovf", OVF, mon_e.ovf);
`endif
          if (chk_lat) chk("latency", cyc - mon_e.cyc, STAGES);
        end
      end else if (OUT_VALID) begin
        held    = 1'b1;
        held_o  = O;
        held_co = CO;
      end
      if (IN_VALID && IN_READY) sb.push_back(model(A, B, SUB, cyc));
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    int n = 0;
    A        = a;
    B        = b;
    SUB      = s;
    IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("send_accept", IN_READY, 1'b1);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    n_assert++;
    assert ((sb.size() == 0) === 1'b1) else begin
      n_fail++;
      $error("FAIL drain: observed %0d beats outstanding, expected 0", sb.size());
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    RST       = 1'b1;
    IN_VALID  = 1'b0;
    A         = '0;
    B         = '0;
    SUB       = 1'b0;
    OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", OUT_VALID, 1'b0);
    chk("rst_o", O, '0);
    chk("rst_co", CO, 1'b0);
`ifdef CARRY_CHAIN_PIPE_OVF_EN
    chk("rst_ovf", OVF, 1'b0);
`endif
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_in_ready", IN_READY, 1'b1);
    @(posedge CLK);
    #1;

    // Directed beats, no stall, exact latency
    chk_lat = 1'b1;
    send(16'h1234, 16'h0FCD, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    send(16'h0003, 16'h0005, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'h0000, 16'h0001, 1'b1);
    send(16'h8000, 16'h0001, 1'b1);
    drain();

    // Full stall: output must hold and input must be refused
    chk_lat   = 1'b0;
    OUT_READY = 1'b0;
    send(16'hA5A5, 16'h5A5A, 1'b0);
    send(16'h1000, 16'h2000, 1'b1);
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    chk("stall_out_valid", OUT_VALID, 1'b1);
    chk("stall_in_ready", IN_READY, 1'b0);
    @(posedge CLK);
    #1;
    OUT_READY = 1'b1;
    drain();

    // Random beats under random back-pressure
    for (int i = 0; i < 8; i++) begin
      A         = WIDTH'($urandom);
      B         = WIDTH'($urandom);
      SUB       = 1'($urandom_range(0, 1));
      IN_VALID  = 1'b1;
      OUT_READY = 1'($urandom_range(0, 1));
      g = 0;
      @(negedge CLK);
      while (!IN_READY && g < 50) begin
        @(posedge CLK);
        #1;
        OUT_READY = 1'($urandom_range(0, 1));
        @(negedge CLK);
        g++;
      end
      chk("rand_accept", IN_READY, 1'b1);
      @(posedge CLK);
      #1;
      IN_VALID  = 1'b0;
      OUT_READY = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge CLK);
        #1;
      end
    end
    OUT_READY = 1'b1;
    drain();

    // Reset with three beats in flight
    send(16'h1111, 16'h2222, 1'b0);
    send(16'h3333, 16'h4444, 1'b0);
    send(16'h5555, 16'h6666, 1'b1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    sb.delete();
    for (int i = 0; i < STAGES; i++) begin
      @(negedge CLK);
      chk("post_rst_out_valid", OUT_VALID, 1'b0);
      if (i == 0) chk("post_rst_in_ready", IN_READY, 1'b1);
    end
    repeat (10) @(negedge CLK);
    @(posedge CLK);
    #1;
    chk_lat = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
